// File: rtl/vga_rect_fill.sv
// Drawing engine feeding vga_adapter. One start request turns into a raster stream of
// pixel writes: single pixel, clipped filled rectangle, or full-screen clear.
module vga_rect_fill #(
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int COLOUR_BITS = 3,
    parameter int X_MAX       = 159,
    parameter int Y_MAX       = 119
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [X_BITS-1:0]      x0,
    input  logic [Y_BITS-1:0]      y0,
    input  logic [X_BITS-1:0]      w,
    input  logic [Y_BITS-1:0]      h,
    input  logic [COLOUR_BITS-1:0] colour_in,
    output logic [X_BITS-1:0]      x,
    output logic [Y_BITS-1:0]      y,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

    localparam logic [X_BITS:0]   X_LIM = (X_BITS+1)'(X_MAX);
    localparam logic [Y_BITS:0]   Y_LIM = (Y_BITS+1)'(Y_MAX);
    localparam logic [X_BITS:0]   X_ONE = (X_BITS+1)'(1);
    localparam logic [Y_BITS:0]   Y_ONE = (Y_BITS+1)'(1);
    localparam logic [X_BITS-1:0] X_INC = X_BITS'(1);
    localparam logic [Y_BITS-1:0] Y_INC = Y_BITS'(1);

    state_t                   state, state_nx;
    logic [X_BITS-1:0]        x_start, x_start_nx, x_end, x_end_nx, x_nx;
    logic [Y_BITS-1:0]        y_end, y_end_nx, y_nx;
    logic [COLOUR_BITS-1:0]   colour_nx;
    logic                     plot_nx, busy_nx, done_nx;

    logic [X_BITS:0]          x_lo, x_hi;
    logic [Y_BITS:0]          y_lo, y_hi;
    logic                     req_empty;

    // Request bounds carry one extra bit so x0+w-1 never wraps before clipping.
    always_comb begin
        x_lo      = {1'b0, x0};
        y_lo      = {1'b0, y0};
        x_hi      = x_lo;
        y_hi      = y_lo;
        req_empty = 1'b0;
        case (mode)
            2'b01: begin
                x_hi      = x_lo + {1'b0, w} - X_ONE;
                y_hi      = y_lo + {1'b0, h} - Y_ONE;
                req_empty = (w == '0) || (h == '0);
            end
            2'b10: begin
                x_lo = '0;
                y_lo = '0;
                x_hi = X_LIM;
                y_hi = Y_LIM;
            end
            default: ;
        endcase
        if (mode != 2'b10 && (x_lo > X_LIM || y_lo > Y_LIM))
            req_empty = 1'b1;
        if (x_hi > X_LIM)
            x_hi = X_LIM;
        if (y_hi > Y_LIM)
            y_hi = Y_LIM;
    end

    always_comb begin
        state_nx   = state;
        x_start_nx = x_start;
        x_end_nx   = x_end;
        y_end_nx   = y_end;
        x_nx       = x;
        y_nx       = y;
        colour_nx  = colour;
        plot_nx    = 1'b0;
        busy_nx    = 1'b0;
        done_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (start && mode != 2'b11) begin
                    if (req_empty) begin
                        state_nx = FINISH;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx   = DRAW;
                        plot_nx    = 1'b1;
                        busy_nx    = 1'b1;
                        x_nx       = x_lo[X_BITS-1:0];
                        y_nx       = y_lo[Y_BITS-1:0];
                        colour_nx  = colour_in;
                        x_start_nx = x_lo[X_BITS-1:0];
                        x_end_nx   = x_hi[X_BITS-1:0];
                        y_end_nx   = y_hi[Y_BITS-1:0];
                    end
                end
            end
            DRAW: begin
                // x/y hold the pixel on the bus this cycle; decide the following one.
                if (x == x_end && y == y_end) begin
                    state_nx = FINISH;
                    done_nx  = 1'b1;
                end else begin
                    plot_nx = 1'b1;
                    busy_nx = 1'b1;
                    if (x == x_end) begin
                        x_nx = x_start;
                        y_nx = y + Y_INC;
                    end else begin
                        x_nx = x + X_INC;
                    end
                end
            end
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            x_start <= '0;
            x_end   <= '0;
            y_end   <= '0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            x_start <= x_start_nx;
            x_end   <= x_end_nx;
            y_end   <= y_end_nx;
            x       <= x_nx;
            y       <= y_nx;
            colour  <= colour_nx;
            plot    <= plot_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

endmodule

// File: doc/vga_rect_fill.md
# vga_rect_fill

Parametrised drawing engine that sits between user control logic and `vga_adapter`. It turns a single start request into a stream of pixel writes on the adapter's `x`/`y`/`colour`/`plot` inputs, one pixel per clock. It replaces direct switch-driven single-pixel plotting with three modes: single pixel, clipped filled rectangle, and full-screen clear.

## Interface
- `X_BITS`, 8: x coordinate width (matches adapter `x`).
- `Y_BITS`, 7: y coordinate width (matches adapter `y`).
- `COLOUR_BITS`, 3: colour width (3 × `BITS_PER_COLOUR_CHANNEL`).
- `X_MAX`, 159: last visible column.
- `Y_MAX`, 119: last visible row.

Ports:
- `CLOCK_50`  in  1  system clock; all state on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `mode`  in  2  00 = pixel, 01 = rectangle, 10 = clear screen, 11 = reserved (ignored).
- `x0`  in  X_BITS  origin column.
- `y0`  in  Y_BITS  origin row.
- `w`  in  X_BITS  rectangle width in pixels (rectangle mode only).
- `h`  in  Y_BITS  rectangle height in pixels (rectangle mode only).
- `colour_in`  in  COLOUR_BITS  fill colour.
- `x`  out  X_BITS  pixel column to adapter.
- `y`  out  Y_BITS  pixel row to adapter.
- `colour`  out  COLOUR_BITS  pixel colour to adapter.
- `plot`  out  1  write enable to adapter.
- `busy`  out  1  high while the request is being drawn.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, DRAW, FINISH.
- IDLE behaviour:
  - On `start` with mode 00/01/10, latch `colour_in` and the bounds.
  - Pixel mode: bounds are (x0,y0)..(x0,y0).
  - Rectangle mode: bounds are (x0,y0)..(x0+w−1, y0+h−1).
  - Clear mode: bounds are (0,0)..(X_MAX,Y_MAX); `x0`/`y0`/`w`/`h` are ignored.
- Bound arithmetic uses X_BITS+1 / Y_BITS+1 bits so it never wraps.
- Clipping: end column = min(x0+w−1, X_MAX); end row = min(y0+h−1, Y_MAX).
- Empty requests go IDLE→FINISH with no plots. A request is empty if any of these hold:
  - w = 0 or h = 0 in rectangle mode;
  - x0 > X_MAX or y0 > Y_MAX in pixel or rectangle mode.
- Non-empty requests go IDLE→DRAW.
- DRAW behaviour:
  - Raster order: x increments from the start column to the end column, then x reloads and y increments.
  - One pixel is output per cycle, with `plot` = 1.
  - After the pixel at (end column, end row), go to FINISH.
- FINISH: `done` = 1 for one cycle, then IDLE.
- `start` is ignored in DRAW and FINISH. Mode 11 is ignored in IDLE: no busy, no done.
- Input changes after the latch cycle do not affect the draw in progress.

## Timing
- All outputs are registered.
- Reset values (asynchronous, immediate on `resetn` = 0):
  - `x` = 0, `y` = 0, `colour` = 0;
  - `plot` = 0, `busy` = 0, `done` = 0;
  - state = IDLE.
- `start` sampled high at edge N with a non-empty request:
  - `plot` = `busy` = 1 from cycle N+1 for exactly P consecutive cycles;
  - P = clipped width × clipped height (1 for pixel mode, (X_MAX+1)(Y_MAX+1) for clear).
- `done` = 1 at cycle N+1+P, with `busy` = 0 in that same cycle.
- Earliest next accepted `start` is at edge N+2+P.
- Empty request: `done` = 1 at cycle N+1, with no `plot` and no `busy`.
- `x`/`y`/`colour` are valid in every cycle where `plot` = 1; they hold their last values otherwise.
- Reset asserted mid-DRAW aborts the draw: no `done`, and no further plots after reset.
- Throughput is exactly 1 pixel/cycle; there are no stall cycles at row wrap.

## Test plan
- **Pixel:** mode 00, (42,17), colour 6, start at N → `plot` only at N+1 with x=42, y=17, colour=6; `done` at N+2.
- **Rectangle:** mode 01, (10,20), w=3, h=2, colour 5 → 6 consecutive plots (10,20), (11,20), (12,20), (10,21), (11,21), (12,21); `done` on the 7th cycle.
- **Clipping:** mode 01, (158,118), w=4, h=4 → exactly 4 plots (158,118), (159,118), (158,119), (159,119).
- **Empty request:** mode 01, (200,5) → zero plots, `done` at N+1.
- **Clear screen and busy-ignore:** mode 10, colour 1 → 19200 plots, first (0,0), last (159,119). A `start` pulsed mid-draw causes no extra plots, and `done` occurs only once.
- **Reset mid-draw:** `resetn` low during a clear → `plot`/`busy` drop to 0 immediately and no `done` follows. After release, a pixel request (3,3) completes normally.
